// File: rtl/bus_bridge_mux_pkg.sv
// Shared types and constants for the CPU-to-peripheral bridge: FSM state
// encoding, default error read data and the default peripheral address map.
package bus_bridge_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Read data returned for unmapped accesses and timeouts.
  localparam logic [31:0] DEF_RDATA = 32'hFFFF_FFFF;

  // Default peripheral windows (channel order: DRAM, 7-seg, LED, switch,
  // button, counter).
  localparam logic [31:0] BASE_DRAM = 32'h0000_0000;
  localparam logic [31:0] MASK_DRAM = 32'hFFFF_0000;
  localparam logic [31:0] BASE_SEG  = 32'hFFFF_FC00;
  localparam logic [31:0] MASK_SEG  = 32'hFFFF_FFF0;
  localparam logic [31:0] BASE_LED  = 32'hFFFF_FC60;
  localparam logic [31:0] MASK_LED  = 32'hFFFF_FFF0;
  localparam logic [31:0] BASE_SW   = 32'hFFFF_FC70;
  localparam logic [31:0] MASK_SW   = 32'hFFFF_FFF0;
  localparam logic [31:0] BASE_BTN  = 32'hFFFF_FC80;
  localparam logic [31:0] MASK_BTN  = 32'hFFFF_FFF0;
  localparam logic [31:0] BASE_CNT  = 32'hFFFF_FC90;
  localparam logic [31:0] MASK_CNT  = 32'hFFFF_FFF0;

  localparam logic [6*32-1:0] DEF_SLV_BASE =
    {BASE_CNT, BASE_BTN, BASE_SW, BASE_LED, BASE_SEG, BASE_DRAM};
  localparam logic [6*32-1:0] DEF_SLV_MASK =
    {MASK_CNT, MASK_BTN, MASK_SW, MASK_LED, MASK_SEG, MASK_DRAM};

endpackage

// File: rtl/bridge_addr_decoder.sv
// Combinational address decoder: compares an address against N_SLV
// base/mask windows and reports a one-hot hit, lowest index winning.
module bridge_addr_decoder #(
  parameter int N_SLV  = 6,
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0]       addr,
  input  logic [N_SLV*ADDR_W-1:0] base,
  input  logic [N_SLV*ADDR_W-1:0] mask,
  output logic [N_SLV-1:0]        hit_onehot,
  output logic                    hit
);

  // Scan from the highest index down so the lowest matching index is the
  // last assignment and therefore wins on overlapping windows.
  always_comb begin
    hit_onehot = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if ((addr & mask[i*ADDR_W +: ADDR_W]) ==
          (base[i*ADDR_W +: ADDR_W] & mask[i*ADDR_W +: ADDR_W])) begin
        hit_onehot = '0;
        hit_onehot[i] = 1'b1;
      end
    end
  end

  assign hit = |hit_onehot;

endmodule

// File: rtl/bus_bridge_mux.sv
// CPU data-bus bridge: decodes the access address onto one of N_SLV slave
// channels, waits for that slave's ready (bounded by TIMEOUT cycles) and
// returns a registered one-cycle response, with an error for unmapped
// addresses and timeouts.
//
// Handshake: the CPU raises cpu_req with address/data; it is taken only
// while the bridge is idle, and the access completes on the single cycle
// cpu_ready is high (cpu_rdata/cpu_err valid in that cycle). Towards a
// slave, sl_req[k] stays high with stable sl_we/sl_addr/sl_wdata until the
// first cycle sl_ready[k] is sampled high; ready on other channels is ignored.
module bus_bridge_mux
  import bus_bridge_mux_pkg::*;
#(
  parameter int                          N_SLV         = 6,
  parameter int                          DATA_W        = 32,
  parameter int                          ADDR_W        = 32,
  parameter logic [N_SLV*ADDR_W-1:0]     SLV_BASE      = DEF_SLV_BASE,
  parameter logic [N_SLV*ADDR_W-1:0]     SLV_MASK      = DEF_SLV_MASK,
  parameter int                          TIMEOUT       = 16,
  parameter logic [DATA_W-1:0]           DEFAULT_RDATA = DATA_W'(DEF_RDATA)
) (
  input  logic                    clk_from_cpu,
  input  logic                    rst_from_cpu,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  output logic                    cpu_ready,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    cpu_err,
  output logic [N_SLV-1:0]        sl_req,
  output logic                    sl_we,
  output logic [ADDR_W-1:0]       sl_addr,
  output logic [DATA_W-1:0]       sl_wdata,
  input  logic [N_SLV*DATA_W-1:0] sl_rdata,
  input  logic [N_SLV-1:0]        sl_ready,
  output state_t                  fsm_state
);

  // One extra bit over clog2 so TIMEOUT-1 always fits without wrapping.
  localparam int              CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [N_SLV-1:0]   dec_onehot;
  logic               dec_hit;
  logic [DATA_W-1:0]  sel_rdata;
  logic               sel_ready;

  bridge_addr_decoder #(
    .N_SLV  (N_SLV),
    .ADDR_W (ADDR_W)
  ) u_dec (
    .addr       (cpu_addr),
    .base       (SLV_BASE),
    .mask       (SLV_MASK),
    .hit_onehot (dec_onehot),
    .hit        (dec_hit)
  );

  // Read-data and ready of the active channel, selected by the held one-hot
  // sl_req; other channels contribute nothing.
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (sl_req[i]) sel_rdata = sel_rdata | sl_rdata[i*DATA_W +: DATA_W];
    end
    sel_ready = |(sl_ready & sl_req);
  end

  // Bridge FSM with latched slave-side request and registered CPU response.
  always_ff @(posedge clk_from_cpu) begin
    if (rst_from_cpu) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      sl_req    <= '0;
      sl_we     <= 1'b0;
      sl_addr   <= '0;
      sl_wdata  <= '0;
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      cpu_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cpu_req) begin
            if (dec_hit) begin
              sl_req   <= dec_onehot;
              sl_we    <= cpu_we;
              sl_addr  <= cpu_addr;
              sl_wdata <= cpu_wdata;
              cnt      <= '0;
              state    <= ST_ACCESS;
            end else begin
              cpu_ready <= 1'b1;
              cpu_err   <= 1'b1;
              cpu_rdata <= DEFAULT_RDATA;
              state     <= ST_RESP;
            end
          end
        end
        ST_ACCESS: begin
          // Ready is tested first so it beats a simultaneous timeout.
          if (sel_ready) begin
            sl_req    <= '0;
            cpu_ready <= 1'b1;
            cpu_err   <= 1'b0;
            cpu_rdata <= sl_we ? '0 : sel_rdata;
            state     <= ST_RESP;
          end else if (cnt == CNT_LAST) begin
            sl_req    <= '0;
            cpu_ready <= 1'b1;
            cpu_err   <= 1'b1;
            cpu_rdata <= DEFAULT_RDATA;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state  <= ST_IDLE;
          sl_req <= '0;
        end
      endcase
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_bus_bridge_mux.sv
// Bench for bus_bridge_mux with three channels and TIMEOUT=4: a table of
// access vectors with a behavioural slave, plus a reset-mid-access sequence.
module tb_bus_bridge_mux;
  import bus_bridge_mux_pkg::*;

  localparam int NS = 3;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;
  localparam logic [NS*AW-1:0] BASES = {32'hFFFF_F060, 32'hFFFF_F000, 32'h0000_0000};
  localparam logic [NS*AW-1:0] MASKS = {32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'hFFFF_0000};

  logic             clk = 1'b0;
  logic             rst;
  logic             cpu_req;
  logic             cpu_we;
  logic [AW-1:0]    cpu_addr;
  logic [DW-1:0]    cpu_wdata;
  logic             cpu_ready;
  logic [DW-1:0]    cpu_rdata;
  logic             cpu_err;
  logic [NS-1:0]    sl_req;
  logic             sl_we;
  logic [AW-1:0]    sl_addr;
  logic [DW-1:0]    sl_wdata;
  logic [NS*DW-1:0] sl_rdata;
  logic [NS-1:0]    sl_ready;
  state_t           fsm_state;

  int tests = 0;
  int fails = 0;

  // scoreboard: {err, rdata} expected for each accepted access
  logic [DW:0] exp_q[$];

  bus_bridge_mux #(
    .N_SLV(NS), .DATA_W(DW), .ADDR_W(AW),
    .SLV_BASE(BASES), .SLV_MASK(MASKS),
    .TIMEOUT(TO), .DEFAULT_RDATA(32'hFFFF_FFFF)
  ) dut (
    .clk_from_cpu(clk), .rst_from_cpu(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .sl_req(sl_req), .sl_we(sl_we), .sl_addr(sl_addr), .sl_wdata(sl_wdata),
    .sl_rdata(sl_rdata), .sl_ready(sl_ready), .fsm_state(fsm_state)
  );

  // clock
  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    int            ch;        // target channel, -1 if unmapped
    int            wait_n;    // ACCESS cycle index where ready rises, -1 never
    logic [31:0]   srdata;    // slave read data on the target channel
    logic [NS-1:0] other_rdy; // ready asserted on non-target channels
    logic [NS-1:0] exp_req;
    int            exp_lat;
    logic          exp_err;
    logic [31:0]   exp_rdata;
  } vec_t;

  vec_t vecs[10];

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  // Drive one access and follow it to its response, acting as the slave.
  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    int acc;
    bit got;
    logic [DW:0] e;
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = v.we;
    cpu_addr  = v.addr;
    cpu_wdata = v.wdata;
    for (int i = 0; i < NS; i++) sl_rdata[i*DW +: DW] = $urandom;
    if (v.ch >= 0) sl_rdata[v.ch*DW +: DW] = v.srdata;
    exp_q.push_back({v.exp_err, v.exp_rdata});
    @(posedge clk);
    cyc = 0; acc = 0; got = 0;
    while (!got && cyc < 12) begin
      @(negedge clk);
      cyc++;
      cpu_req   = 1'b0;
      cpu_addr  = $urandom;
      cpu_wdata = $urandom;
      cpu_we    = ~cpu_we;
      sl_ready  = v.other_rdy;
      if (cpu_ready) begin
        got = 1;
        sl_ready = '0;
        check($sformatf("v%0d latency", idx), 64'(cyc), 64'(v.exp_lat));
        check($sformatf("v%0d sl_req_in_resp", idx), 64'(sl_req), 64'(0));
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL v%0d scoreboard: response with empty queue", idx);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("v%0d cpu_err", idx), 64'(cpu_err), 64'(e[DW]));
          check($sformatf("v%0d cpu_rdata", idx), 64'(cpu_rdata), 64'(e[DW-1:0]));
        end
      end else begin
        check($sformatf("v%0d sl_req", idx), 64'(sl_req), 64'(v.exp_req));
        if (sl_req != '0) begin
          check($sformatf("v%0d sl_addr", idx), 64'(sl_addr), 64'(v.addr));
          check($sformatf("v%0d sl_we", idx), 64'(sl_we), 64'(v.we));
          if (v.we) check($sformatf("v%0d sl_wdata", idx), 64'(sl_wdata), 64'(v.wdata));
          if (v.ch >= 0 && v.wait_n == acc) sl_ready[v.ch] = 1'b1;
          acc++;
        end
      end
    end
    if (!got) begin
      tests++; fails++;
      sl_ready = '0;
      $display("FAIL v%0d no_cpu_ready: got none within 12 cycles, expected latency %0d", idx, v.exp_lat);
    end
  endtask

  initial begin
    logic [31:0] rnd;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    sl_rdata = '0; sl_ready = '0;
    rnd = $urandom;

    //             we    addr           wdata          ch wait srdata         oth     req     lat err rdata
    vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,         0,  0, 32'h1234_5678, 3'b000, 3'b001, 2, 1'b0, 32'h1234_5678};
    vecs[1] = '{1'b1, 32'hFFFF_F000, 32'hA5A5_0001, 1,  2, 32'hDEAD_0000, 3'b000, 3'b010, 4, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 32'h8000_0000, 32'h0,        -1, -1, 32'h0,         3'b000, 3'b000, 1, 1'b1, 32'hFFFF_FFFF};
    vecs[3] = '{1'b0, 32'hFFFF_F064, 32'h0,         2, -1, 32'h0,         3'b011, 3'b100, 5, 1'b1, 32'hFFFF_FFFF};
    vecs[4] = '{1'b0, 32'hFFFF_F064, 32'h0,         2,  3, 32'h0000_0042, 3'b000, 3'b100, 5, 1'b0, 32'h0000_0042};
    vecs[5] = '{1'b1, 32'hFFFF_F06C, 32'h0BAD_CAFE, 2,  1, 32'h5555_5555, 3'b001, 3'b100, 3, 1'b0, 32'h0};
    vecs[6] = '{1'b0, 32'h0000_FFFC, 32'h0,         0,  1, 32'hDEAD_BEEF, 3'b110, 3'b001, 3, 1'b0, 32'hDEAD_BEEF};
    vecs[7] = '{1'b0, 32'h0001_0000, 32'h0,        -1, -1, 32'h0,         3'b111, 3'b000, 1, 1'b1, 32'hFFFF_FFFF};
    vecs[8] = '{1'b1, 32'hFFFF_F001, 32'h1111_2222,-1, -1, 32'h0,         3'b000, 3'b000, 1, 1'b1, 32'hFFFF_FFFF};
    vecs[9] = '{1'b0, 32'hFFFF_F000, 32'h0,         1,  0, rnd,           3'b000, 3'b010, 2, 1'b0, rnd};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", 64'(fsm_state), 64'(ST_IDLE));
    check("rst_outputs", {cpu_ready, cpu_err, sl_we, sl_req, 58'(0)}, 64'(0));
    check("rst_cpu_rdata", 64'(cpu_rdata), 64'(0));
    check("rst_sl_addr", 64'(sl_addr), 64'(0));
    check("rst_sl_wdata", 64'(sl_wdata), 64'(0));
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // reset in the second ACCESS cycle aborts the access silently
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hFFFF_F064;
    @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b0;
    check("mid_rst acc1 sl_req", 64'(sl_req), 64'(3'b100));
    @(negedge clk);
    check("mid_rst acc2 state", 64'(fsm_state), 64'(ST_ACCESS));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst sl_req", 64'(sl_req), 64'(0));
    check("mid_rst state", 64'(fsm_state), 64'(ST_IDLE));
    for (int i = 0; i < 4; i++) begin
      check("mid_rst cpu_ready", 64'(cpu_ready), 64'(0));
      if (i < 3) @(negedge clk);
    end
    run_vec('{1'b0, 32'h0000_0000, 32'h0, 0, 0, 32'hCAFE_F00D, 3'b000, 3'b001, 2, 1'b0, 32'hCAFE_F00D}, 10);

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
